link_uart_tx: RTL and testbench

//  Board-to-board link transmitter: serialises game event bytes (0x30 start-as-fire,
//  0x31 start-as-water, 0x32 game lost) onto one UART wire towards the peer board.

---
 rtl/link_uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_link_uart_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : link_uart_tx
// Description : Board-to-board UART transmitter. Edge-qualifies strobed event
//               bytes, buffers them in a small FIFO and sends 8N1 frames.
// Revision    : 1.0 - initial release
// ============================================================================
module link_uart_tx #(
    parameter int CLK_HZ    = 65_000_000,
    parameter int BAUD      = 115_200,
    parameter int DEPTH     = 4,
    parameter int STOP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     txd,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     overflow
);

    localparam int c_div   = CLK_HZ / BAUD;
    localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_f = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0] c_div_last  = c_cnt_w'(c_div - 1);
    localparam logic [2:0]         c_stop_last = 3'(STOP_BITS - 1);
    localparam logic [c_cnt_f-1:0] c_depth     = c_cnt_f'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state, w_state_n;
    logic [c_cnt_w-1:0]   r_bit_cnt, w_bit_cnt_n;
    logic [2:0]           r_idx, w_idx_n;
    logic [7:0]           r_shift, w_shift_n;
    logic                 r_txd, w_txd_n;
    logic                 r_busy, w_busy_n;

    logic [7:0]           r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_cnt_f-1:0]   r_count;
    logic                 r_overflow;
    logic                 r_prev_valid;
    logic [7:0]           r_prev_data;

    logic                 w_push, w_pop, w_wr, w_drop, w_full, w_bit_end;
    logic [7:0]           w_head;

    // A byte counts once per rising strobe, or again when the data changes under a held strobe
    assign w_push    = tx_valid & (~r_prev_valid | (tx_data != r_prev_data));
    assign w_full    = (r_count == c_depth);
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_bit_end = (r_bit_cnt == c_div_last);

    always_comb begin
        w_state_n   = r_state;
        w_bit_cnt_n = r_bit_cnt;
        w_idx_n     = r_idx;
        w_shift_n   = r_shift;
        w_txd_n     = r_txd;
        w_busy_n    = r_busy;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_txd_n  = 1'b1;
                w_busy_n = 1'b0;
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_n   = S_START;
                    w_bit_cnt_n = '0;
                    w_shift_n   = w_head;
                    w_txd_n     = 1'b0;
                    w_busy_n    = 1'b1;
                end
            end
            S_START: begin
                w_bit_cnt_n = r_bit_cnt + c_cnt_w'(1);
                if (w_bit_end) begin
                    w_bit_cnt_n = '0;
                    w_idx_n     = '0;
                    w_txd_n     = r_shift[0];
                    w_state_n   = S_DATA;
                end
            end
            S_DATA: begin
                w_bit_cnt_n = r_bit_cnt + c_cnt_w'(1);
                if (w_bit_end) begin
                    w_bit_cnt_n = '0;
                    w_shift_n   = r_shift >> 1;
                    w_txd_n     = r_shift[1];
                    w_idx_n     = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_idx_n   = '0;
                        w_txd_n   = 1'b1;
                        w_state_n = S_STOP;
                    end
                end
            end
            S_STOP: begin
                w_bit_cnt_n = r_bit_cnt + c_cnt_w'(1);
                if (w_bit_end) begin
                    w_bit_cnt_n = '0;
                    if (r_idx == c_stop_last) begin
                        w_idx_n = '0;
                        // Chain the next frame straight out of the stop bit to avoid an idle gap
                        if (r_count != '0) begin
                            w_pop     = 1'b1;
                            w_state_n = S_START;
                            w_shift_n = w_head;
                            w_txd_n   = 1'b0;
                        end else begin
                            w_state_n = S_IDLE;
                            w_busy_n  = 1'b0;
                            w_txd_n   = 1'b1;
                        end
                    end else begin
                        w_idx_n = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_txd_n   = 1'b1;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_prev_valid <= 1'b0;
            r_prev_data  <= '0;
        end else begin
            r_state      <= w_state_n;
            r_bit_cnt    <= w_bit_cnt_n;
            r_idx        <= w_idx_n;
            r_shift      <= w_shift_n;
            r_txd        <= w_txd_n;
            r_busy       <= w_busy_n;
            r_prev_valid <= tx_valid;
            r_prev_data  <= tx_data;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            if (w_wr && !w_pop)      r_count <= r_count + c_cnt_f'(1);
            else if (w_pop && !w_wr) r_count <= r_count - c_cnt_f'(1);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= tx_data;
    end

    assign txd        = r_txd;
    assign busy       = r_busy;
    assign fifo_count = r_count;
    assign fifo_full  = w_full;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_link_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_uart_tx
// Description : Scoreboard bench for link_uart_tx; a line decoder feeds frames
//               that each scenario compares against its expected bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_uart_tx;

    localparam int DIV   = 564;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       txd, busy, fifo_full, overflow;
    logic [2:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_data[$];
    int         rx_t0[$];
    logic       rx_err[$];

    logic       mon_act = 1'b0;
    int         mon_t0 = 0;
    logic [7:0] mon_sh = 8'h00;
    logic       mon_err = 1'b0;

    link_uart_tx #(
        .CLK_HZ(65_000_000), .BAUD(115_200), .DEPTH(4), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .txd(txd), .busy(busy), .fifo_count(fifo_count),
        .fifo_full(fifo_full), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples each bit in its middle relative to the detected start edge
    always @(negedge clk) begin
        if (rst) begin
            mon_act <= 1'b0;
        end else if (!mon_act) begin
            if (txd === 1'b0) begin
                mon_act <= 1'b1;
                mon_t0  <= cyc;
                mon_err <= 1'b0;
            end
        end else if (((cyc - mon_t0) % DIV) == DIV / 2) begin
            if ((cyc - mon_t0) / DIV == 0) begin
                if (txd !== 1'b0) mon_err <= 1'b1;
            end else if ((cyc - mon_t0) / DIV <= 8) begin
                mon_sh[(cyc - mon_t0) / DIV - 1] <= txd;
            end else begin
                rx_data.push_back(mon_sh);
                rx_t0.push_back(mon_t0);
                rx_err.push_back(mon_err | (txd !== 1'b1));
                mon_act <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && fifo_count === 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd got=%b want=1", txd); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got=%b want=0", fifo_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single();
        int tv, blen;
        bit ok;
        logic [7:0] e;
        tick();
        tx_data = 8'h30; tx_valid = 1'b1; tv = cyc;
        exp_q.push_back(8'h30);
        tick();
        tx_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL single_lat1 txd got=%b want=1", txd); end
        @(negedge clk);
        n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL single_lat2 txd got=%b want=0", txd); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got=%b want=1", busy); end
        blen = 1;
        for (int i = 0; i < FRAME + 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            blen++;
        end
        n_cmp++; if (blen != FRAME) begin n_bad++; $display("FAIL single_busy_len got=%0d want=%0d", blen, FRAME); end
        wait_idle(100, ok);
        n_cmp++; if (rx_data.size() != 1) begin n_bad++; $display("FAIL single_frames got=%0d want=1", rx_data.size()); end
        while (rx_data.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (rx_data[0] !== e) begin n_bad++; $display("FAIL single_byte got=%h want=%h", rx_data[0], e); end
            n_cmp++; if (rx_t0[0] != tv + 2) begin n_bad++; $display("FAIL single_start got=%0d want=%0d", rx_t0[0], tv + 2); end
            n_cmp++; if (rx_err[0] !== 1'b0) begin n_bad++; $display("FAIL single_framing got=%b want=0", rx_err[0]); end
            void'(rx_data.pop_front()); void'(rx_t0.pop_front()); void'(rx_err.pop_front());
        end
        rx_data.delete(); rx_t0.delete(); rx_err.delete(); exp_q.delete();
    endtask

    task automatic test_held_level();
        int peak;
        bit ok;
        logic [7:0] e;
        tick();
        tx_data = 8'h31; tx_valid = 1'b1;
        exp_q.push_back(8'h31);
        peak = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        tick();
        tx_valid = 1'b0;
        n_cmp++; if (peak != 1) begin n_bad++; $display("FAIL held_peak got=%0d want=1", peak); end
        wait_idle(FRAME + 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL held_timeout got=%b want=1", ok); end
        n_cmp++; if (rx_data.size() != 1) begin n_bad++; $display("FAIL held_frames got=%0d want=1", rx_data.size()); end
        while (rx_data.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (rx_data[0] !== e || rx_err[0] !== 1'b0) begin n_bad++; $display("FAIL held_byte got=%h err=%b want=%h", rx_data[0], rx_err[0], e); end
            void'(rx_data.pop_front()); void'(rx_t0.pop_front()); void'(rx_err.pop_front());
        end
        rx_data.delete(); rx_t0.delete(); rx_err.delete(); exp_q.delete();
    endtask

    task automatic test_data_change();
        bit ok;
        int prev_t0;
        logic [7:0] e;
        tick();
        tx_data = 8'h30; tx_valid = 1'b1; exp_q.push_back(8'h30);
        tick();
        tx_data = 8'h32; exp_q.push_back(8'h32);
        tick();
        repeat (10) tick();
        tx_valid = 1'b0;
        wait_idle(2 * FRAME + 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL change_timeout got=%b want=1", ok); end
        n_cmp++; if (rx_data.size() != 2) begin n_bad++; $display("FAIL change_frames got=%0d want=2", rx_data.size()); end
        prev_t0 = -1;
        while (rx_data.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (rx_data[0] !== e || rx_err[0] !== 1'b0) begin n_bad++; $display("FAIL change_byte got=%h err=%b want=%h", rx_data[0], rx_err[0], e); end
            if (prev_t0 >= 0) begin
                n_cmp++; if (rx_t0[0] != prev_t0 + FRAME) begin n_bad++; $display("FAIL change_gap got=%0d want=%0d", rx_t0[0], prev_t0 + FRAME); end
            end
            prev_t0 = rx_t0[0];
            void'(rx_data.pop_front()); void'(rx_t0.pop_front()); void'(rx_err.pop_front());
        end
        rx_data.delete(); rx_t0.delete(); rx_err.delete(); exp_q.delete();
    endtask

    task automatic test_overflow();
        bit ok;
        int prev_t0;
        logic [7:0] e;
        for (int k = 0; k < 6; k++) begin
            tick();
            tx_data = 8'h30 + 8'(k); tx_valid = 1'b1;
            // First byte is in flight, four fit the FIFO, the sixth finds it full
            if (k < 5) exp_q.push_back(8'h30 + 8'(k));
            tick();
            tx_valid = 1'b0;
        end
        @(negedge clk);
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got=%0d want=4", fifo_count); end
        n_cmp++; if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full got=%b want=1", fifo_full); end
        wait_idle(5 * FRAME + 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL ovf_timeout got=%b want=1", ok); end
        n_cmp++; if (rx_data.size() != 5) begin n_bad++; $display("FAIL ovf_frames got=%0d want=5", rx_data.size()); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
        prev_t0 = -1;
        while (rx_data.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (rx_data[0] !== e || rx_err[0] !== 1'b0) begin n_bad++; $display("FAIL ovf_byte got=%h err=%b want=%h", rx_data[0], rx_err[0], e); end
            if (prev_t0 >= 0) begin
                n_cmp++; if (rx_t0[0] != prev_t0 + FRAME) begin n_bad++; $display("FAIL ovf_gap got=%0d want=%0d", rx_t0[0], prev_t0 + FRAME); end
            end
            prev_t0 = rx_t0[0];
            void'(rx_data.pop_front()); void'(rx_t0.pop_front()); void'(rx_err.pop_front());
        end
        rx_data.delete(); rx_t0.delete(); rx_err.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        bit seen;
        logic [7:0] pat [3];
        pat[0] = 8'hA5; pat[1] = 8'h11; pat[2] = 8'h22;
        for (int k = 0; k < 3; k++) begin
            tick();
            tx_data = pat[k]; tx_valid = 1'b1;
            exp_q.push_back(pat[k]);
            tick();
            tx_valid = 1'b0;
        end
        seen = 1'b0; t0 = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin seen = 1'b1; t0 = cyc; end
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL mid_start_seen got=%b want=1", seen); end
        while (cyc < t0 + 4 * DIV + 10) @(negedge clk);
        n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL mid_bit3 got=%b want=0", txd); end
        n_cmp++; if (fifo_count !== 3'd2) begin n_bad++; $display("FAIL mid_queued got=%0d want=2", fifo_count); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (txd !== 1'b0) begin n_bad++; $display("FAIL mid_pre_rst got=%b want=0", txd); end
        @(negedge clk);
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL mid_rst_txd got=%b want=1", txd); end
        n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL mid_rst_count got=%0d want=0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL mid_rst_overflow got=%b want=0", overflow); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
        tick();
        rst = 1'b0;
        exp_q.delete();
        repeat (2 * FRAME) @(negedge clk);
        n_cmp++; if (rx_data.size() != 0) begin n_bad++; $display("FAIL mid_no_frames got=%0d want=0", rx_data.size()); end
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL mid_idle_txd got=%b want=1", txd); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_held_level();
        test_data_change();
        test_overflow();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
